// File: rtl/neural_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// neural_layer_sequencer_if
// Command/status/handshake bundle between the inference sequencer and its
// environment (processor command register plus init/load/PE/writeback
// engines).
//   master : the environment. It drives the start/abort request, the layer
//            configuration and the engine completion strobes, and it observes
//            the sequencer status and begin_* levels.
//   slave  : the sequencer. It sees the same signals from the other side.
// ---------------------------------------------------------------------------
interface neural_layer_sequencer_if #(
  parameter int STAGE_W = 8,
  parameter int TILE_W  = 4
);
  // Environment -> sequencer
  logic               run_inference;
  logic               abort;
  logic [STAGE_W-1:0] total_layers;
  logic [TILE_W-1:0]  tiles_per_layer;
  logic               registers_initialized;
  logic               data_loaded;
  logic               data_processed;
  logic               output_written;

  // Sequencer -> environment
  logic               ready;
  logic               busy;
  logic               begin_initialize_registers;
  logic               begin_load_data;
  logic               begin_process_data;
  logic               begin_write_output;
  logic [STAGE_W-1:0] stage;
  logic [TILE_W-1:0]  tile;
  logic               done;
  logic               error;
  logic [1:0]         error_code;

  modport master (
    output run_inference, abort, total_layers, tiles_per_layer,
           registers_initialized, data_loaded, data_processed, output_written,
    input  ready, busy, begin_initialize_registers, begin_load_data,
           begin_process_data, begin_write_output, stage, tile, done, error,
           error_code
  );

  modport slave (
    input  run_inference, abort, total_layers, tiles_per_layer,
           registers_initialized, data_loaded, data_processed, output_written,
    output ready, busy, begin_initialize_registers, begin_load_data,
           begin_process_data, begin_write_output, stage, tile, done, error,
           error_code
  );
endinterface

// File: rtl/neural_layer_sequencer.sv
// ---------------------------------------------------------------------------
// neural_layer_sequencer
// Sequences one inference: register init, then for every layer one or more
// load/process tile passes, then a single output write. A per-phase watchdog
// sends the sequencer to a sticky error state; abort cancels a run or clears
// the error state. done pulses for one cycle after a successful run.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : slave side of neural_layer_sequencer_if (command, configuration,
//           engine handshakes, status). Every output is either a register or
//           a decode of the state register; nothing is combinational from an
//           input.
// ---------------------------------------------------------------------------
module neural_layer_sequencer #(
  parameter int               STAGE_W    = 8,
  parameter int               TILE_W     = 4,
  parameter int               TMO_W      = 16,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 16'd4096
) (
  input logic                     clk,
  input logic                     reset,
  neural_layer_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PROC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ZERO    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  logic [2:0]         state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic [STAGE_W-1:0] layers_q, layers_d;   // latched total_layers
  logic [TILE_W-1:0]  tiles_q, tiles_d;     // latched tile count, never 0
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic [1:0]         code_q, code_d;
  logic               done_q, done_d;

  logic busy_st;
  logic timeout;

  assign busy_st = (state_q == S_INIT) || (state_q == S_LOAD) ||
                   (state_q == S_PROC) || (state_q == S_WRITE);

  // wdog_q counts completed cycles in the current phase, so the phase has
  // used its full budget when this is its TMO_CYCLES-th cycle.
  assign timeout = busy_st && (TMO_CYCLES != '0) &&
                   (wdog_q == TMO_CYCLES - TMO_W'(1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    stage_d  = stage_q;
    tile_d   = tile_q;
    layers_d = layers_q;
    tiles_d  = tiles_q;
    code_d   = code_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run_inference) begin
          layers_d = bus.total_layers;
          tiles_d  = (bus.tiles_per_layer == '0) ? TILE_W'(1) : bus.tiles_per_layer;
          stage_d  = '0;
          tile_d   = '0;
          if (bus.total_layers == '0) begin
            state_d = S_ERR;
            code_d  = ERR_ZERO;
          end else begin
            state_d = S_INIT;
            code_d  = ERR_NONE;
          end
        end
      end

      S_ERR: begin
        if (bus.abort) state_d = S_IDLE;
      end

      S_INIT, S_LOAD, S_PROC, S_WRITE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_ERR;
          code_d  = ERR_TIMEOUT;
        end else begin
          case (state_q)
            S_INIT: if (bus.registers_initialized) state_d = S_LOAD;
            S_LOAD: if (bus.data_loaded)           state_d = S_PROC;
            S_PROC: begin
              if (bus.data_processed) begin
                // layers_q/tiles_q are >= 1 in any busy state, so the
                // "minus one" bounds cannot wrap.
                if (tile_q < tiles_q - TILE_W'(1)) begin
                  tile_d  = tile_q + TILE_W'(1);
                  state_d = S_LOAD;
                end else if (stage_q < layers_q - STAGE_W'(1)) begin
                  tile_d  = '0;
                  stage_d = stage_q + STAGE_W'(1);
                  state_d = S_LOAD;
                end else begin
                  state_d = S_WRITE;
                end
              end
            end
            default: begin // S_WRITE
              if (bus.output_written) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog restarts on every state change and only runs in busy states.
  always_comb begin
    wdog_d = '0;
    if (state_d == state_q && busy_st) wdog_d = wdog_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and all state uses <= so every
    // register updates from the same pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      tile_q   <= '0;
      layers_q <= '0;
      tiles_q  <= '0;
      wdog_q   <= '0;
      code_q   <= ERR_NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      tile_q   <= tile_d;
      layers_q <= layers_d;
      tiles_q  <= tiles_d;
      wdog_q   <= wdog_d;
      code_q   <= code_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready                      = (state_q == S_IDLE);
  assign bus.busy                       = busy_st;
  assign bus.begin_initialize_registers = (state_q == S_INIT);
  assign bus.begin_load_data            = (state_q == S_LOAD);
  assign bus.begin_process_data         = (state_q == S_PROC);
  assign bus.begin_write_output         = (state_q == S_WRITE);
  assign bus.stage                      = stage_q;
  assign bus.tile                       = tile_q;
  assign bus.done                       = done_q;
  assign bus.error                      = (state_q == S_ERR);
  assign bus.error_code                 = code_q;

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neural_layer_sequencer
// Drives whole inferences with random engine latencies and random noise on
// the handshake lines that must be ignored. Expected behaviour comes from
// nested layer/tile loops: each phase names the begin_* level it must see
// and the (stage, tile) it must show. The DUT watchdog is set to 8 cycles;
// engine latencies stay below that.
// ---------------------------------------------------------------------------
module tb_neural_layer_sequencer;

  typedef enum int {P_IDLE, P_INIT, P_LOAD, P_PROC, P_WRITE, P_ERR} phase_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  neural_layer_sequencer_if #(.STAGE_W(8), .TILE_W(4)) bus ();

  neural_layer_sequencer #(
    .STAGE_W(8), .TILE_W(4), .TMO_W(16), .TMO_CYCLES(16'd8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ready, busy, init, load, proc, write, done, error}
  function automatic logic [7:0] exp_flags(input phase_t ph, input logic dn);
    logic [7:0] f;
    f = 8'h00;
    case (ph)
      P_IDLE:  f = 8'b1000_0000;
      P_INIT:  f = 8'b0110_0000;
      P_LOAD:  f = 8'b0101_0000;
      P_PROC:  f = 8'b0100_1000;
      P_WRITE: f = 8'b0100_0100;
      P_ERR:   f = 8'b0000_0001;
      default: f = 8'h00;
    endcase
    f[1] = dn;
    return f;
  endfunction

  function automatic logic [7:0] obs_flags();
    return {bus.ready, bus.busy, bus.begin_initialize_registers,
            bus.begin_load_data, bus.begin_process_data,
            bus.begin_write_output, bus.done, bus.error};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.run_inference         = 1'b0;
    bus.abort                 = 1'b0;
    bus.registers_initialized = 1'b0;
    bus.data_loaded           = 1'b0;
    bus.data_processed        = 1'b0;
    bus.output_written        = 1'b0;
  endtask

  task automatic check_state(input string tag, input phase_t ph, input logic dn,
                             input int st, input int ti);
    check({tag, ".flags"}, 32'(obs_flags()), 32'(exp_flags(ph, dn)));
    check({tag, ".stage"}, 32'(bus.stage), 32'(st));
    check({tag, ".tile"},  32'(bus.tile),  32'(ti));
  endtask

  // Random noise on every handshake line; the caller then forces the one
  // line that matters for the current phase.
  task automatic noise();
    bus.run_inference         = 1'($urandom);
    bus.registers_initialized = 1'($urandom);
    bus.data_loaded           = 1'($urandom);
    bus.data_processed        = 1'($urandom);
    bus.output_written        = 1'($urandom);
  endtask

  task automatic set_ack(input phase_t ph, input logic v);
    case (ph)
      P_INIT:  bus.registers_initialized = v;
      P_LOAD:  bus.data_loaded           = v;
      P_PROC:  bus.data_processed        = v;
      P_WRITE: bus.output_written        = v;
      default: ;
    endcase
  endtask

  // Called just after the edge that entered ph; leaves just after the edge
  // that left it. The engine answers delay cycles after its begin rises.
  task automatic do_phase(input phase_t ph, input int delay, input int st, input int ti);
    for (int i = 0; i <= delay; i++) begin
      check_state(ph.name(), ph, 1'b0, st, ti);
      noise();
      set_ack(ph, i == delay);
      step();
    end
  endtask

  task automatic start_run(input int layers, input int tiles);
    quiet();
    bus.total_layers    = 8'(layers);
    bus.tiles_per_layer = 4'(tiles);
    bus.run_inference   = 1'b1;
    step();
    bus.run_inference   = 1'b0;
    // Configuration must have been latched; scramble the live inputs.
    bus.total_layers    = 8'($urandom);
    bus.tiles_per_layer = 4'($urandom);
  endtask

  function automatic int rd();
    return int'($urandom_range(0, 5));
  endfunction

  task automatic full_run(input int layers, input int tiles);
    int te;
    te = (tiles == 0) ? 1 : tiles;
    start_run(layers, tiles);
    do_phase(P_INIT, rd(), 0, 0);
    for (int l = 0; l < layers; l++)
      for (int t = 0; t < te; t++) begin
        do_phase(P_LOAD, rd(), l, t);
        do_phase(P_PROC, rd(), l, t);
      end
    do_phase(P_WRITE, rd(), layers - 1, te - 1);
    quiet();
    check_state("done_idle", P_IDLE, 1'b1, layers - 1, te - 1);
    check("done_code", 32'(bus.error_code), 32'd0);
    step();
    check_state("after_done", P_IDLE, 1'b0, layers - 1, te - 1);
  endtask

  // ack_at < 0: data_loaded never comes; otherwise it comes in LOAD cycle
  // ack_at (0-based). Budget is 8 cycles, so ack_at = 7 loses to the timeout.
  task automatic timeout_case(input int ack_at);
    start_run(1, 1);
    do_phase(P_INIT, rd(), 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (ack_at >= 0 && i > ack_at) break;
      check_state("tmo_load", P_LOAD, 1'b0, 0, 0);
      noise();
      bus.data_loaded = (i == ack_at);
      step();
    end
    quiet();
    if (ack_at >= 0 && ack_at < 7) begin
      check_state("tmo_early_ack", P_PROC, 1'b0, 0, 0);
      bus.abort = 1'b1;
      step();
      quiet();
      check_state("tmo_abort_proc", P_IDLE, 1'b0, 0, 0);
    end else begin
      check_state("tmo_err", P_ERR, 1'b0, 0, 0);
      check("tmo_code", 32'(bus.error_code), 32'd2);
      bus.run_inference = 1'b1;
      bus.total_layers  = 8'd2;
      step();
      step();
      check_state("tmo_err_hold", P_ERR, 1'b0, 0, 0);
      quiet();
      bus.abort = 1'b1;
      step();
      quiet();
      check_state("tmo_cleared", P_IDLE, 1'b0, 0, 0);
      check("tmo_code_kept", 32'(bus.error_code), 32'd2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "time limit reached");
  end

  initial begin
    quiet();
    bus.total_layers    = '0;
    bus.tiles_per_layer = '0;
    reset = 1'b1;
    step();
    step();
    check_state("reset", P_IDLE, 1'b0, 0, 0);
    check("reset_code", 32'(bus.error_code), 32'd0);
    reset = 1'b0;
    step();

    // Abort in IDLE has no effect.
    bus.abort = 1'b1;
    step();
    quiet();
    check_state("abort_idle", P_IDLE, 1'b0, 0, 0);

    full_run(3, 1);
    full_run(2, 3);
    full_run(1, 0);

    // Zero-layer configuration goes straight to ERR.
    start_run(0, 2);
    check_state("zero_err", P_ERR, 1'b0, 0, 0);
    check("zero_code", 32'(bus.error_code), 32'd1);
    noise();
    step();
    quiet();
    check_state("zero_hold", P_ERR, 1'b0, 0, 0);
    bus.abort = 1'b1;
    step();
    quiet();
    check_state("zero_abort", P_IDLE, 1'b0, 0, 0);
    check("zero_code_kept", 32'(bus.error_code), 32'd1);

    timeout_case(-1);
    timeout_case(7);
    timeout_case(6);

    // Abort in PROC beats a simultaneous completion.
    start_run(2, 2);
    do_phase(P_INIT, rd(), 0, 0);
    do_phase(P_LOAD, rd(), 0, 0);
    check_state("abort_proc_pre", P_PROC, 1'b0, 0, 0);
    bus.abort          = 1'b1;
    bus.data_processed = 1'b1;
    step();
    quiet();
    check_state("abort_proc", P_IDLE, 1'b0, 0, 0);
    step();
    check_state("abort_no_done", P_IDLE, 1'b0, 0, 0);

    // Reset during WRITE, with output_written high, returns reset values.
    start_run(2, 2);
    do_phase(P_INIT, rd(), 0, 0);
    for (int l = 0; l < 2; l++)
      for (int t = 0; t < 2; t++) begin
        do_phase(P_LOAD, rd(), l, t);
        do_phase(P_PROC, rd(), l, t);
      end
    check_state("rst_write_pre", P_WRITE, 1'b0, 1, 1);
    reset              = 1'b1;
    bus.output_written = 1'b1;
    step();
    reset = 1'b0;
    quiet();
    check_state("rst_write", P_IDLE, 1'b0, 0, 0);
    check("rst_write_code", 32'(bus.error_code), 32'd0);
    step();
    check_state("rst_no_done", P_IDLE, 1'b0, 0, 0);

    // Random configurations, including the widest layer index.
    for (int r = 0; r < 4; r++)
      full_run(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    full_run(255, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
